// File: rtl/seg7_pkg.sv
// Shared seven-segment constants for the Nexys 4 DDR display blocks.
// Segment patterns are active-low, seg[6:0] = G..A; anodes are active-low.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [7:0] AN_OFF = 8'hFF;
    localparam logic [7:0] AN_D0  = 8'hFE;
    localparam logic [7:0] AN_D1  = 8'hFD;

    localparam logic [7:0] BCD_MAX = 8'h99;

    // Saturate a nibble to a legal BCD digit.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment pattern decoder.
// Ports: bcd [3:0] in, seg [6:0] out (G..A); non-BCD codes blank the digit.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/mod100_down_display.sv
// Mod-100 BCD down counter stepped by rising edges of an asynchronous slow
// clock, with a two-digit multiplexed seven-segment display driver.
// Ports: clk, rst (async high), sclk_in, en, load, load_val[7:0] in;
//        count[7:0], zero, seg[6:0], dp, an[7:0] out.
module mod100_down_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk_in,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] count,
    output logic       zero,
    output logic [6:0] seg,
    output logic       dp,
    output logic [7:0] an
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

    logic          s1_q, s2_q, s_prev_q;
    logic          tick;
    logic [7:0]    count_q, count_d;
    logic          hit_q, hit_d;
    logic          zero_q, zero_d;
    logic [RW-1:0] ref_q, ref_d;
    logic          sel_q, sel_d;
    logic [6:0]    seg_q, seg_d;
    logic [7:0]    an_q, an_d;
    logic [3:0]    ones, tens, digit;
    logic [6:0]    dec_seg;
    logic          ref_wrap;

    assign ones = count_q[3:0];
    assign tens = count_q[7:4];
    assign tick = s2_q & ~s_prev_q;

    // Counter: load wins, otherwise a qualified tick steps down with borrow.
    always_comb begin
        count_d = count_q;
        hit_d   = 1'b0;
        if (load) begin
            count_d = {clamp_digit(load_val[7:4]),
                       clamp_digit(load_val[3:0])};
        end else if (tick && en) begin
            hit_d = (count_q == 8'h01);
            if (ones != 4'd0) begin
                count_d[3:0] = ones - 4'd1;
            end else if (tens != 4'd0) begin
                count_d = {tens - 4'd1, 4'd9};
            end else begin
                count_d = BCD_MAX;
            end
        end
    end

    // hit_q marks the edge that reached 00; zero follows one edge later.
    assign zero_d = hit_q;

    assign ref_wrap = (ref_q == REF_LAST);
    assign ref_d    = ref_wrap ? '0 : ref_q + RW'(1);
    assign sel_d    = sel_q ^ ref_wrap;
    assign digit    = sel_d ? tens : ones;

    bcd_to_seg7 u_dec (
        .bcd (digit),
        .seg (dec_seg)
    );

    // Outputs follow the next digit select so seg/an switch together.
    always_comb begin
        an_d  = sel_d ? AN_D1 : AN_D0;
        seg_d = dec_seg;
        if (BLANK_LZ && sel_d && (tens == 4'd0)) begin
            seg_d = SEG_BLANK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s_prev_q <= 1'b0;
            count_q  <= BCD_MAX;
            hit_q    <= 1'b0;
            zero_q   <= 1'b0;
            ref_q    <= '0;
            sel_q    <= 1'b0;
            seg_q    <= SEG_BLANK;
            an_q     <= AN_OFF;
        end else begin
            s1_q     <= sclk_in;
            s2_q     <= s1_q;
            s_prev_q <= s2_q;
            count_q  <= count_d;
            hit_q    <= hit_d;
            zero_q   <= zero_d;
            ref_q    <= ref_d;
            sel_q    <= sel_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign count = count_q;
    assign zero  = zero_q;
    assign seg   = seg_q;
    assign an    = an_q;
    assign dp    = 1'b1;

endmodule
